// File: rtl/ndp_result_streamer.sv
// rtl/ndp_result_streamer.sv - captures an NDP core result and streams it out as acknowledged words
module ndp_result_streamer #(
  parameter  int WIDTH      = 16,
  parameter  int ARR_WIDTH  = 4,
  parameter  int ARR_HEIGHT = 4,
  parameter  int SYS_WIDTH  = 64,
  parameter  int SYS_HEIGHT = 1,
  parameter  int OUT_WIDTH  = 32,
  localparam int TOTAL      = ARR_WIDTH * SYS_WIDTH * ARR_HEIGHT * SYS_HEIGHT * WIDTH,
  localparam int NWORDS     = TOTAL / OUT_WIDTH,
  localparam int CW         = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 calc_done_flag,
  input  logic [TOTAL-1:0]     out_c,
  output logic                 data_out_flag,
  output logic [OUT_WIDTH-1:0] data_out,
  input  logic                 data_out_ack,
  output logic                 data_last,
  output logic                 busy,
  output logic                 drain_done
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;

  localparam logic [CW-1:0] LAST_IDX = CW'(NWORDS - 1);

  state_e                           state_q;
  logic                             calc_prev_q;
  logic [NWORDS-1:0][OUT_WIDTH-1:0] buffer_q;
  logic [CW-1:0]                    cnt_q;
  logic                             flag_q;
  logic [OUT_WIDTH-1:0]             data_q;
  logic                             last_q;
  logic                             busy_q;
  logic                             drain_q;

  logic                             rise;
  logic                             xfer;
  logic [CW-1:0]                    next_idx_d;

  assign rise       = calc_done_flag & ~calc_prev_q;
  assign xfer       = flag_q & data_out_ack;
  assign next_idx_d = cnt_q + CW'(1);

  // calc_prev_q resets high so a level already present at reset release is not taken as a new result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      calc_prev_q <= 1'b1;
      buffer_q    <= '0;
      cnt_q       <= '0;
      flag_q      <= 1'b0;
      data_q      <= '0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      drain_q     <= 1'b0;
    end else begin
      calc_prev_q <= calc_done_flag;
      case (state_q)
        IDLE: begin
          if (rise) begin
            buffer_q <= out_c;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            flag_q   <= 1'b1;
            data_q   <= out_c[OUT_WIDTH-1:0];
            last_q   <= (NWORDS == 1);
            state_q  <= SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            if (cnt_q == LAST_IDX) begin
              flag_q  <= 1'b0;
              last_q  <= 1'b0;
              busy_q  <= 1'b0;
              drain_q <= 1'b1;
              state_q <= DONE;
            end else begin
              cnt_q  <= next_idx_d;
              data_q <= buffer_q[next_idx_d];
              last_q <= (next_idx_d == LAST_IDX);
            end
          end
        end
        DONE: begin
          drain_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out_flag = flag_q;
  assign data_out      = data_q;
  assign data_last     = last_q;
  assign busy          = busy_q;
  assign drain_done    = drain_q;

endmodule

// File: tb/tb_ndp_result_streamer.sv
// tb/tb_ndp_result_streamer.sv - scenario-table bench with an element-level reference model
module tb_ndp_result_streamer;

  localparam int WIDTH  = 16;
  localparam int OUTW   = 32;
  localparam int TOTAL  = 16384;
  localparam int NELEM  = TOTAL / WIDTH;
  localparam int NWORDS = TOTAL / OUTW;
  localparam int BUDGET = 4000;

  logic             clk;
  logic             reset;
  logic             calc_done_flag;
  logic [TOTAL-1:0] out_c;
  logic             data_out_flag;
  logic [OUTW-1:0]  data_out;
  logic             data_out_ack;
  logic             data_last;
  logic             busy;
  logic             drain_done;

  ndp_result_streamer dut (
    .clk           (clk),
    .reset         (reset),
    .calc_done_flag(calc_done_flag),
    .out_c         (out_c),
    .data_out_flag (data_out_flag),
    .data_out      (data_out),
    .data_out_ack  (data_out_ack),
    .data_last     (data_last),
    .busy          (busy),
    .drain_done    (drain_done)
  );

  typedef struct {
    string name;
    int    pat;        // 0: element i = i, 1: random elements
    int    ack_mode;   // 0: tied high, 1: 1,0,0,1 repeating, 2: random
    bit    mutate;
    bit    rerise;
    int    rst_at;
    int    exp_xfers;
    int    exp_drains;
  } scen_t;

  scen_t       scen [5];
  logic [15:0] elem [NELEM];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  string       cur;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s actual=%0h required=%0h", cur, name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int k);
    return {elem[2*k+1], elem[2*k]};
  endfunction

  task automatic run_stream(input scen_t s);
    int idx, t, post, drains, rise_cyc;
    bit a, hit_reset;
    for (int i = 0; i < NELEM; i++) elem[i] = (s.pat == 0) ? 16'(i) : 16'($urandom);
    for (int i = 0; i < NELEM; i++) out_c[i*WIDTH +: WIDTH] = elem[i];
    data_out_ack   = 1'b0;
    calc_done_flag = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_flag", data_out_flag, 0);
    rise_cyc       = cyc;
    calc_done_flag = 1'b1;
    @(negedge clk);
    chk("word0_flag", data_out_flag, 1);
    chk("word0_data", data_out, exp_word(0));
    idx = 0; t = 0; post = 0; drains = 0; hit_reset = 0;
    while (post < 4 && t < BUDGET) begin
      if (s.rst_at != 0 && idx == s.rst_at) begin
        #2 reset = 1'b1;
        #1;
        chk("async_rst_flag", data_out_flag, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_last", data_last, 0);
        hit_reset = 1;
        break;
      end
      if (drain_done) begin
        drains++;
        chk("drain_after_last", idx, NWORDS);
        chk("drain_first_idle_cycle", post, 0);
        if (s.ack_mode == 0) chk("drain_latency", cyc - rise_cyc, NWORDS + 1);
      end
      if (idx < NWORDS) begin
        chk("flag", data_out_flag, 1);
        chk("data", data_out, exp_word(idx));
        chk("last", data_last, idx == NWORDS - 1);
        chk("busy", busy, 1);
      end else begin
        chk("flag_after_end", data_out_flag, 0);
        chk("busy_after_end", busy, 0);
        post++;
      end
      case (s.ack_mode)
        0:       a = 1'b1;
        1:       a = (t % 4 == 0) || (t % 4 == 3);
        default: a = 1'($urandom_range(0, 1));
      endcase
      data_out_ack = a;
      if (data_out_flag && a && idx < NWORDS) idx++;
      if (s.mutate && idx == 5) out_c = '1;
      if (s.rerise) begin
        if (idx == 98) calc_done_flag = 1'b0;
        else if (idx >= 100) calc_done_flag = 1'b1;
      end
      t++;
      @(negedge clk);
    end
    if (hit_reset) begin
      repeat (2) begin
        @(negedge clk);
        chk("rst_no_drain", drain_done, 0);
        chk("rst_flag_low", data_out_flag, 0);
      end
      reset = 1'b0;
      repeat (10) begin
        @(negedge clk);
        chk("post_rst_no_stream", data_out_flag, 0);
      end
    end else begin
      chk("stream_completed", post >= 4, 1);
    end
    chk("transfers", idx, s.exp_xfers);
    chk("drain_pulses", drains, s.exp_drains);
  endtask

  initial begin
    scen[0] = '{"incr_ack_high",  0, 0, 0, 0, 0,   NWORDS, 1};
    scen[1] = '{"rand_1001_mut",  1, 1, 1, 0, 0,   NWORDS, 1};
    scen[2] = '{"rand_ack_rerise",1, 2, 0, 1, 0,   NWORDS, 1};
    scen[3] = '{"incr_rst_300",   0, 1, 0, 0, 300, 300,    0};
    scen[4] = '{"rand_after_rst", 1, 0, 0, 0, 0,   NWORDS, 1};

    reset          = 1'b1;
    calc_done_flag = 1'b1;
    data_out_ack   = 1'b1;
    out_c          = '0;
    cur            = "reset";
    repeat (3) @(negedge clk);
    chk("rst_flag",  data_out_flag, 0);
    chk("rst_data",  data_out, 0);
    chk("rst_last",  data_last, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_drain", drain_done, 0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("held_level_no_stream", data_out_flag, 0);
    end

    for (int i = 0; i < 5; i++) begin
      cur = scen[i].name;
      run_stream(scen[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
